// File: rtl/pc_redirect_ctrl.sv
// Control-flow redirect sequencer: captures EX-stage branch/jump outcomes, drives the
// fetch redirect handshake, flushes wrong-path pipeline registers and counts redirects.
module pc_redirect_ctrl #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ex_valid,
    input  logic                 i_stall,
    input  logic [1:0]           i_pcsrc,
    input  logic [WIDTH-1:0]     i_branch_target,
    input  logic [WIDTH-1:0]     i_jalr_target,
    input  logic                 i_imem_ready,
    output logic                 o_redirect_valid,
    output logic [WIDTH-1:0]     o_redirect_pc,
    output logic                 o_flush_ifid,
    output logic                 o_flush_idex,
    output logic                 o_hold_fetch,
    output logic                 o_misalign,
    output logic [CNT_WIDTH-1:0] o_redirect_cnt
);

    // state    | meaning
    // RUN      | normal fetch, waiting for a taken branch/jump in EX
    // REDIRECT | requesting new PC from fetch, front end held and flushed
    // DRAIN    | one cycle squashing the fetch issued from the old PC
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

    logic [1:0]           state_q,    state_d;
    logic [WIDTH-1:0]     target_q,   target_d;
    logic                 misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0]     jalr_aligned;
    logic                 capture;

    assign jalr_aligned = i_jalr_target & ~WIDTH'(1);
    assign capture      = i_ex_valid && !i_stall && (i_pcsrc != 2'b00);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (capture) begin
                    target_d   = (i_pcsrc == 2'b11) ? jalr_aligned : i_branch_target;
                    misalign_d = target_d[1];
                    state_d    = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (i_imem_ready) begin
                    state_d = ST_DRAIN;
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            target_q   <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // Moore outputs; the PC bus reads zero outside REDIRECT.
    assign o_redirect_valid = (state_q == ST_REDIRECT);
    assign o_redirect_pc    = (state_q == ST_REDIRECT) ? target_q : '0;
    assign o_flush_ifid     = (state_q == ST_REDIRECT) || (state_q == ST_DRAIN);
    assign o_flush_idex     = (state_q == ST_REDIRECT);
    assign o_hold_fetch     = (state_q == ST_REDIRECT);
    assign o_misalign       = misalign_q;
    assign o_redirect_cnt   = cnt_q;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Sequences control-flow redirects in the IF/ID/EX pipeline. Takes the resolved PC-source code and targets from the EX-stage branch detector. Drives the fetch PC redirect with a ready handshake to instruction memory, flushes wrong-path IF/ID and ID/EX contents, and holds the front end until the new fetch is accepted. Sits between the EX-stage branch logic and the PC/fetch unit. Keeps a saturating redirect counter for performance debug.

Parameters:
WIDTH, 32, address/data width of PC and targets
CNT_WIDTH, 16, width of redirect counter

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  reset; asynchronous, active-high
i_ex_valid  input  1  EX stage holds a valid instruction
i_stall  input  1  load-use hazard stall active this cycle
i_pcsrc  input  2  00 sequential, 01 branch taken, 10 jal, 11 jalr
i_branch_target  input  WIDTH  PC+imm target for branch/jal
i_jalr_target  input  WIDTH  rs1+imm target for jalr
i_imem_ready  input  1  fetch unit accepts redirect PC this cycle
o_redirect_valid  output  1  redirect request to fetch
o_redirect_pc  output  WIDTH  redirect address
o_flush_ifid  output  1  squash IF/ID register
o_flush_idex  output  1  squash ID/EX register
o_hold_fetch  output  1  freeze PC and IF/ID advance
o_misalign  output  1  one-cycle pulse: redirect target not 4-byte aligned
o_redirect_cnt  output  CNT_WIDTH  accepted redirects, saturating

Behaviour:
- Reset (async, i_rst=1): state RUN. All outputs 0. Target register 0. Counter 0. Reset mid-REDIRECT/DRAIN abandons the request immediately; no redirect is issued after release.
- States: RUN, REDIRECT, DRAIN. All outputs are Moore, decoded from registered state and target.
- RUN: capture when i_ex_valid=1 and i_stall=0 and i_pcsrc!=00.
  - Target register loads i_branch_target for 01/10, and {i_jalr_target[WIDTH-1:1],1'b0} for 11.
  - Next state REDIRECT.
  - i_pcsrc=00, i_ex_valid=0 or i_stall=1: stay in RUN with no action.
- REDIRECT: o_redirect_valid=1, o_redirect_pc=target reg, o_flush_ifid=1, o_flush_idex=1, o_hold_fetch=1.
  - i_imem_ready=1: handshake done; counter increments (saturates at all-ones); next state DRAIN.
  - i_imem_ready=0: stay in REDIRECT. o_redirect_pc stays stable; flushes stay asserted every cycle.
- DRAIN: exactly one cycle. o_flush_ifid=1 squashes the fetch already in flight from the old PC. o_redirect_valid=0, o_flush_idex=0, o_hold_fetch=0. Next state RUN.
- Events outside RUN: i_ex_valid/i_pcsrc are ignored in REDIRECT and DRAIN, since EX holds only flushed bubbles. There is no queuing.
- Latency: capture at edge E. Redirect is visible in cycle E+1. Minimum penalty is 3 cycles: capture, REDIRECT, DRAIN.
- o_misalign: pulses for 1 cycle on entry to REDIRECT when target[1]=1 (after jalr bit0 clear). The redirect still proceeds; trap handling is outside this block.
- Simultaneous i_stall=1 with i_pcsrc!=00 in RUN: no capture. The event is re-presented when the stall releases.
- Counter increments only on REDIRECT & i_imem_ready, once per redirect.

Test Plan:
- Reset, then i_ex_valid=1, i_pcsrc=01, i_branch_target=0x100, i_imem_ready=1 -> next cycle redirect_valid=1, pc=0x100, both flushes=1, hold=1; cycle after: only flush_ifid=1; then RUN; cnt=1.
- jalr: i_pcsrc=11, i_jalr_target=0x203 -> redirect_pc=0x202, o_misalign pulses 1 cycle.
- i_imem_ready held 0 for 3 cycles in REDIRECT -> redirect_valid/flushes/hold stay 1 with pc stable for 4 cycles total; cnt increments once, on the ready cycle.
- i_pcsrc=10 with i_stall=1 -> no redirect; same event with i_stall=0 next cycle -> REDIRECT entered the following cycle.
- Second i_pcsrc=01 presented during REDIRECT and DRAIN -> ignored; cnt increments only once. Assert i_rst mid-REDIRECT -> all outputs 0 immediately; RUN after release.
- CNT_WIDTH=2: 5 back-to-back accepted redirects -> o_redirect_cnt saturates at 3.
